// File: rtl/acc_drain_if.sv
// Capture/drain bus between the PE column accumulator, the drain stage and the writeback path.
// slave: the drain stage itself; master: whatever sits around it (accumulator + writeback).
interface acc_drain_if #(
    parameter int WIDTH  = 32,
    parameter int OWIDTH = 16,
    parameter int DEPTH  = 4
);
    logic signed [WIDTH-1:0]           acc;
    logic                              capture;
    logic                              acc_clr;
    logic                              ready;
    logic                              valid;
    logic signed [OWIDTH-1:0]          data;
    logic [$clog2(DEPTH+1)-1:0]        count;
    logic                              overflow;
    logic                              sat;

    modport slave (
        input  acc, capture, ready,
        output acc_clr, valid, data, count, overflow, sat
    );

    modport master (
        output acc, capture, ready,
        input  acc_clr, valid, data, count, overflow, sat
    );
endinterface

// File: rtl/acc_drain.sv
// Accumulator drain stage: capture + clear, narrow to OWIDTH, buffer in a DEPTH-entry FIFO.
// Define ACC_DRAIN_SAT_EN to clamp instead of truncate and report clamping on sat.
module acc_drain #(
    parameter int WIDTH  = 32,
    parameter int OWIDTH = 16,
    parameter int DEPTH  = 4
) (
    input logic        clk,
    input logic        rst_n,
    acc_drain_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [OWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              overflow_q;
    logic              full;
    logic              valid;
    logic              push;
    logic              pop;
    logic [OWIDTH-1:0] narrow;

    assign full  = (count == CW'(DEPTH));
    assign valid = (count != '0);
    assign pop   = valid & bus.ready;
    // Gated by rst_n so the accumulator is never cleared while the FIFO is held in reset.
    assign push  = bus.capture & rst_n & (~full | pop);

`ifdef ACC_DRAIN_SAT_EN
    logic clamp;
    logic sat_q;

    if (OWIDTH < WIDTH) begin : g_clamp
        localparam logic signed [WIDTH-1:0] SAT_MAX =
            {{(WIDTH-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
        localparam logic signed [WIDTH-1:0] SAT_MIN =
            {{(WIDTH-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

        always_comb begin
            clamp  = 1'b0;
            narrow = bus.acc[OWIDTH-1:0];
            if (bus.acc > SAT_MAX) begin
                clamp  = 1'b1;
                narrow = SAT_MAX[OWIDTH-1:0];
            end else if (bus.acc < SAT_MIN) begin
                clamp  = 1'b1;
                narrow = SAT_MIN[OWIDTH-1:0];
            end
        end
    end else begin : g_pass
        assign clamp  = 1'b0;
        assign narrow = bus.acc[OWIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (push && clamp) begin
            sat_q <= 1'b1;
        end
    end

    assign bus.sat = sat_q;
`else
    assign narrow  = bus.acc[OWIDTH-1:0];
    assign bus.sat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= narrow;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (bus.capture && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Head entry is read straight from the storage registers, so a push into an
    // empty FIFO is visible right after its edge.
    assign bus.data     = mem[rd_ptr];
    assign bus.valid    = valid;
    assign bus.count    = count;
    assign bus.acc_clr  = push;
    assign bus.overflow = overflow_q;
endmodule
